// File: rtl/delay_pkg.sv
// Shared definitions for the multi-tap delay line: default geometry and the
// sequencer state encoding.
package delay_pkg;

  localparam int DEF_A_WIDTH = 8;
  localparam int DEF_D_WIDTH = 8;
  localparam int DEF_N_TAPS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram2ports.sv
// Simple dual-port RAM: synchronous write port, synchronous (registered) read
// port with independent addresses. Contents are not reset.
module ram2ports #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/multitap_delay.sv
// Multi-tap delay line: each accepted sample is written into a circular buffer,
// then N_TAPS delayed samples are read back one per cycle and mixed.
module multitap_delay
  import delay_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int N_TAPS  = DEF_N_TAPS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [D_WIDTH-1:0]                  din,
  input  logic [N_TAPS*A_WIDTH-1:0]           tap_offset,
  input  logic [N_TAPS-1:0]                   tap_en,
  output logic                                ready,
  output logic                                out_valid,
  output logic [N_TAPS*D_WIDTH-1:0]           tap_out,
  output logic [D_WIDTH+$clog2(N_TAPS)-1:0]   mix_sum,
  output logic [D_WIDTH-1:0]                  mix_avg,
  output logic                                overrun
);

  localparam int L2      = $clog2(N_TAPS);
  localparam int S_WIDTH = D_WIDTH + L2;

  state_t             state_reg, state_next;
  logic [L2-1:0]      k_reg;
  logic [A_WIDTH-1:0] wr_ptr_reg;
  logic [D_WIDTH-1:0] sample_reg;
  logic [A_WIDTH-1:0] offset_reg [N_TAPS];
  logic [N_TAPS-1:0]  en_reg;
  logic [S_WIDTH-1:0] acc_reg;
  logic [D_WIDTH-1:0] taps_reg [N_TAPS];
  logic [D_WIDTH-1:0] tap_out_reg [N_TAPS];
  logic [S_WIDTH-1:0] mix_sum_reg;
  logic [D_WIDTH-1:0] mix_avg_reg;

  logic               accept;
  logic               drain;
  logic               cap_valid;
  logic [L2-1:0]      cap_idx;
  logic [D_WIDTH-1:0] cap_word;
  logic [S_WIDTH-1:0] sum_final;
  logic [A_WIDTH-1:0] rd_addr;
  logic [D_WIDTH-1:0] rd_data;

  ram2ports #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we      (state_reg == ST_WRITE),
    .wr_addr (wr_ptr_reg),
    .wr_data (sample_reg),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_next = state_reg;
    ready      = (state_reg == ST_IDLE);
    out_valid  = (state_reg == ST_DONE);
    overrun    = in_valid && (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE:  if (in_valid) state_next = ST_WRITE;
      ST_WRITE: state_next = ST_READ;
      ST_READ:  if (k_reg == L2'(N_TAPS - 1)) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Read data lags its address by one cycle, so READ step k captures tap k-1
  // and DRAIN captures the last tap.
  assign accept    = (state_reg == ST_IDLE) && in_valid;
  assign drain     = (state_reg == ST_DRAIN);
  assign cap_valid = ((state_reg == ST_READ) && (k_reg != '0)) || drain;
  assign cap_idx   = drain ? L2'(N_TAPS - 1) : k_reg - L2'(1);
  assign cap_word  = en_reg[cap_idx] ? rd_data : '0;
  assign sum_final = acc_reg + S_WIDTH'(cap_word);
  assign rd_addr   = wr_ptr_reg - offset_reg[k_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      k_reg       <= '0;
      wr_ptr_reg  <= '0;
      acc_reg     <= '0;
      mix_sum_reg <= '0;
      mix_avg_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept)
        acc_reg <= '0;
      else if (cap_valid)
        acc_reg <= sum_final;
      if (state_reg == ST_WRITE)
        k_reg <= '0;
      else if (state_reg == ST_READ)
        k_reg <= k_reg + L2'(1);
      // Results are published on the DRAIN edge so they are visible during DONE
      // alongside the out_valid pulse.
      if (drain) begin
        mix_sum_reg <= sum_final;
        mix_avg_reg <= sum_final[S_WIDTH-1:L2];
      end
      if (state_reg == ST_DONE)
        wr_ptr_reg <= wr_ptr_reg + A_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        taps_reg[i]    <= '0;
        tap_out_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_TAPS; i++) begin
        if (cap_valid && (cap_idx == L2'(i)))
          taps_reg[i] <= cap_word;
        if (drain)
          tap_out_reg[i] <= (i == N_TAPS - 1) ? cap_word : taps_reg[i];
      end
    end
  end

  // Request parameters are frozen at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      sample_reg <= din;
      en_reg     <= tap_en;
      for (int i = 0; i < N_TAPS; i++)
        offset_reg[i] <= tap_offset[i*A_WIDTH +: A_WIDTH];
    end
  end

  generate
    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_out
      assign tap_out[gi*D_WIDTH +: D_WIDTH] = tap_out_reg[gi];
    end
  endgenerate

  assign mix_sum = mix_sum_reg;
  assign mix_avg = mix_avg_reg;

endmodule

// File: tb/tb_multitap_delay.sv
// Self-checking bench for multitap_delay with a circular-buffer reference model
// indexed by sample history.
module tb_multitap_delay;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  din;
  logic [31:0] tap_offset;
  logic [3:0]  tap_en;
  logic        ready;
  logic        out_valid;
  logic [31:0] tap_out;
  logic [9:0]  mix_sum;
  logic [7:0]  mix_avg;
  logic        overrun;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mem_m [256];
  bit         wr_m  [256];
  logic [7:0] wp_m;

  multitap_delay #(.A_WIDTH(8), .D_WIDTH(8), .N_TAPS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .din        (din),
    .tap_offset (tap_offset),
    .tap_en     (tap_en),
    .ready      (ready),
    .out_valid  (out_valid),
    .tap_out    (tap_out),
    .mix_sum    (mix_sum),
    .mix_avg    (mix_avg),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One complete operation; optionally fires a stray strobe mid-operation.
  task automatic do_sample(input logic [7:0] d, input logic [7:0] o0, input logic [7:0] o1,
                           input logic [7:0] o2, input logic [7:0] o3, input logic [3:0] en,
                           input bit ovr);
    logic [7:0] offs [4];
    logic [7:0] exp_t [4];
    bit         kn [4];
    logic [7:0] a;
    int         sum;
    bit         sum_kn;
    int         n;
    offs[0] = o0; offs[1] = o1; offs[2] = o2; offs[3] = o3;
    // reference: write first, then tap k sees the sample offs[k] positions back
    mem_m[wp_m] = d;
    wr_m[wp_m]  = 1'b1;
    sum = 0;
    sum_kn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = wp_m - offs[k];
      if (en[k]) begin
        kn[k]    = wr_m[a];
        exp_t[k] = mem_m[a];
        sum      = sum + int'(mem_m[a]);
        if (!wr_m[a]) sum_kn = 1'b0;
      end else begin
        kn[k]    = 1'b1;
        exp_t[k] = 8'd0;
      end
    end
    wp_m = wp_m + 8'd1;

    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before", 32'(ready), 32'd1);
    in_valid   = 1'b1;
    din        = d;
    tap_offset = {o3, o2, o1, o0};
    tap_en     = en;
    #1 check("overrun_idle", 32'(overrun), 32'd0);
    @(negedge clk);
    in_valid   = 1'b0;
    din        = 8'($urandom);
    tap_offset = $urandom;
    tap_en     = 4'($urandom);
    n = 1;
    check("busy", 32'(ready), 32'd0);
    if (ovr) begin
      @(negedge clk);
      n = 2;
      in_valid = 1'b1;
      din      = ~d;
      #1 check("overrun_pulse", 32'(overrun), 32'd1);
      @(negedge clk);
      n = 3;
      in_valid = 1'b0;
      #1 check("overrun_clear", 32'(overrun), 32'd0);
    end
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd7);
    if (out_valid) begin
      for (int k = 0; k < 4; k++)
        if (kn[k]) check($sformatf("tap%0d", k), 32'(tap_out[k*8 +: 8]), 32'(exp_t[k]));
      if (sum_kn) begin
        check("mix_sum", 32'(mix_sum), 32'(sum));
        check("mix_avg", 32'(mix_avg), 32'(sum >> 2));
      end
    end
    @(negedge clk);
    check("out_valid_pulse", 32'(out_valid), 32'd0);
    check("ready_after", 32'(ready), 32'd1);
    if (sum_kn) check("mix_sum_hold", 32'(mix_sum), 32'(sum));
  endtask

  initial begin
    int seen;
    rst        = 1'b1;
    in_valid   = 1'b0;
    din        = '0;
    tap_offset = '0;
    tap_en     = '0;
    wp_m       = 8'd0;
    for (int i = 0; i < 256; i++) wr_m[i] = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_tap_out", tap_out, 32'd0);
    check("rst_mix_sum", 32'(mix_sum), 32'd0);
    check("rst_mix_avg", 32'(mix_avg), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ramp 1..10, offsets 0..3, all taps
    for (int i = 1; i <= 10; i++) do_sample(8'(i), 8'd0, 8'd1, 8'd2, 8'd3, 4'b1111, 1'b0);
    check("ramp_taps", tap_out, 32'h0708090A);
    check("ramp_sum", 32'(mix_sum), 32'd34);
    check("ramp_avg", 32'(mix_avg), 32'd8);

    // single enabled tap
    do_sample(8'd11, 8'd0, 8'd1, 8'd2, 8'd3, 4'b0001, 1'b0);
    check("en1_taps", tap_out, 32'h0000000B);
    check("en1_sum", 32'(mix_sum), 32'd11);

    // long stream exercising wrap and maximum delay
    for (int n = 0; n < 300; n++) do_sample(8'(n), 8'd0, 8'd255, 8'd100, 8'd1, 4'b1111, 1'b0);
    check("wrap_taps", tap_out, 32'h2AC72C2B);

    // full-scale samples, no overflow
    do_sample(8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 4'b1111, 1'b0);
    check("max_sum", 32'(mix_sum), 32'd1020);
    check("max_avg", 32'(mix_avg), 32'd255);
    check("max_taps", tap_out, 32'hFFFFFFFF);

    // random traffic
    for (int i = 0; i < 40; i++)
      do_sample(8'($urandom), 8'($urandom), 8'($urandom_range(7, 0)), 8'($urandom),
                8'($urandom_range(255, 250)), 4'($urandom), 1'b0);

    // stray strobe while busy is dropped; next sample sees an undisturbed history
    do_sample(8'hC3, 8'd0, 8'd1, 8'd2, 8'd3, 4'b1111, 1'b1);
    do_sample(8'h3C, 8'd0, 8'd1, 8'd2, 8'd3, 4'b1111, 1'b0);

    // reset during READ aborts; the write had already completed
    in_valid   = 1'b1;
    din        = 8'h77;
    tap_offset = {8'd3, 8'd2, 8'd1, 8'd0};
    tap_en     = 4'b1111;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_tap_out", tap_out, 32'd0);
    check("abort_mix_sum", 32'(mix_sum), 32'd0);
    check("abort_mix_avg", 32'(mix_avg), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    mem_m[wp_m] = 8'h77;
    wr_m[wp_m]  = 1'b1;
    wp_m        = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    do_sample(8'h5A, 8'd0, 8'd255, 8'd1, 8'd2, 4'b1111, 1'b0);
    do_sample(8'h5B, 8'd0, 8'd1, 8'd2, 8'd3, 4'b1111, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
